seq_mult_mac: RTL

- Parametrised iterative shift-add multiplier with optional accumulate, successor to the fixed-width micro multiplier in the top-level tile.
- Adds: generic operand width, signed/unsigned mode per operation, start/busy/done handshake and a wrap-around accumulator with sticky overflow.
- Sits behind the tile pin wrapper; the wrapper maps ui_in/uio_in to operands and control, and uo_out to result bytes.

---
 rtl/seq_mult_mac_if.sv | 25 ++
 rtl/seq_mult_mac.sv | 82 ++++++++
 2 files changed

// File: rtl/seq_mult_mac_if.sv
// seq_mult_mac_if: operand, control and result bundle for the sequential multiply-accumulate unit.
interface seq_mult_mac_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
);
    logic               start;
    logic               signed_mode;
    logic               acc_en;
    logic               acc_clr;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [ACC_W-1:0]   acc;
    logic               overflow;
    modport master (
        output start, signed_mode, acc_en, acc_clr, a, b,
        input  busy, done, product, acc, overflow
    );
    modport slave (
        input  start, signed_mode, acc_en, acc_clr, a, b,
        output busy, done, product, acc, overflow
    );
endinterface

// File: rtl/seq_mult_mac.sv
// seq_mult_mac: iterative shift-add multiplier, signed or unsigned per operation, with wrap-around accumulator and sticky overflow.
module seq_mult_mac #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
) (
    input logic           clk,
    input logic           rst,
    seq_mult_mac_if.slave bus
);
    localparam int CW = $clog2(WIDTH+1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand, mplier, a_mag, b_mag;
    logic [2*WIDTH-1:0] partial, partial_nx, product_nx, product_r;
    logic [WIDTH:0]     upper_sum;
    logic [ACC_W-1:0]   acc_r, ext;
    logic [ACC_W:0]     acc_sum;
    logic               neg, sgn, acc_en_r, ovf_r, ovf_nx;
    // Magnitudes are unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    always_comb begin
        a_mag      = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag      = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        upper_sum  = {1'b0, partial[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        partial_nx = {upper_sum, partial[WIDTH-1:1]};
        product_nx = neg ? -partial_nx : partial_nx;
        ext        = sgn ? ACC_W'($signed(product_nx)) : ACC_W'(product_nx);
        acc_sum    = {1'b0, acc_r} + {1'b0, ext};
        ovf_nx     = sgn ? (acc_r[ACC_W-1] == ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_r[ACC_W-1])
                         : acc_sum[ACC_W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            partial   <= '0;
            product_r <= '0;
            acc_r     <= '0;
            neg       <= 1'b0;
            sgn       <= 1'b0;
            acc_en_r  <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                mcand    <= a_mag;
                mplier   <= b_mag;
                neg      <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                sgn      <= bus.signed_mode;
                acc_en_r <= bus.acc_en;
                count    <= CW'(WIDTH);
                partial  <= '0;
                state    <= RUN;
            end else if (state == RUN) begin
                partial <= partial_nx;
                mplier  <= mplier >> 1;
                count   <= count - CW'(1);
                if (count == CW'(1)) begin
                    state     <= DONE;
                    product_r <= product_nx;
                    if (acc_en_r) begin
                        acc_r <= acc_sum[ACC_W-1:0];
                        ovf_r <= ovf_r | ovf_nx;
                    end
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
            // Placed last so a coincident clear overrides the accumulate update.
            if (bus.acc_clr) begin
                acc_r <= '0;
                ovf_r <= 1'b0;
            end
        end
    end
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.product  = product_r;
    assign bus.acc      = acc_r;
    assign bus.overflow = ovf_r;
endmodule
